// File: rtl/seq_divider_ctrl.sv
// seq_divider_ctrl: multi-cycle unsigned restoring divider with start/done handshake.
// Produces one quotient bit per clock, MSB first, through a single WIDTH+1 bit subtractor.
// Optional build macro EARLY_EXIT_EN: a dividend smaller than a non-zero divisor
// finishes straight from IDLE with Q=0, R=A.
module seq_divider_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] dvd;      // dividend, shifts left; quotient bits enter at the LSB
    logic [WIDTH-1:0] dsr;      // latched divisor
    logic [WIDTH-1:0] rem;      // partial remainder
    logic [CW-1:0]    cnt;      // steps still to take
    logic             early;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

`ifdef EARLY_EXIT_EN
    assign early = (A < B);
`else
    assign early = 1'b0;
`endif

    // One restoring step: bring in the next dividend bit and try to subtract the divisor.
    // A non-borrowing result is < divisor, and a borrowing one means the shifted value
    // was < divisor, so either way the new remainder fits in WIDTH bits.
    always_comb begin
        shifted = {rem, dvd[WIDTH-1]};
        trial   = shifted - {1'b0, dsr};
        borrow  = trial[WIDTH];
        rem_nxt = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nxt = {dvd[WIDTH-2:0], ~borrow};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; done and busy are decoded straight from the state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ((B == '0) || early) ? FINISH : RUN;
            RUN:     if (cnt == CW'(1)) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == FINISH);

    // Datapath: latch operands on accept, step in RUN, and load Q/R on the way
    // into FINISH so they are already valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd         <= '0;
            dsr         <= '0;
            rem         <= '0;
            cnt         <= '0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd         <= A;
                        dsr         <= B;
                        rem         <= '0;
                        cnt         <= CW'(WIDTH);
                        Q           <= '0;
                        R           <= '0;
                        div_by_zero <= 1'b0;
                        if (B == '0) begin
                            Q           <= '1;
                            R           <= A;
                            div_by_zero <= 1'b1;
                        end else if (early) begin
                            R <= A;
                        end
                    end
                end
                RUN: begin
                    dvd <= quo_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        Q <= quo_nxt;
                        R <= rem_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_ctrl.sv
// Scoreboard bench for seq_divider_ctrl: the driver pushes expected results,
// the monitor pops and compares whenever done is seen.
module tb_seq_divider_ctrl;

    localparam int W = 8;
`ifdef EARLY_EXIT_EN
    localparam int EE = 1;
`else
    localparam int EE = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] Q, R;

    seq_divider_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .Q(Q), .R(R), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           edge_no;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL spurious_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("Q", int'(Q), int'(e.q));
                chk("R", int'(R), int'(e.r));
                chk("div_by_zero", int'(div_by_zero), int'(e.z));
                chk("done_cycle", cyc, e.edge_no);
                chk("busy_at_done", int'(busy), 1);
            end
        end
    end

    // Issue one start; caller is at a negedge in IDLE
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, output int s);
        A = a; B = b; start = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        A = ~a; B = ~b;           // only the latched copies may matter
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            $display("FAIL timeout: got no done expected done within 40 cycles");
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r,
                          input logic z, input int lat);
        int s;
        exp_t e;
        e.q = q; e.r = r; e.z = z;
        e.edge_no = cyc + 1 + lat;
        sb.push_back(e);
        issue(a, b, s);
        wait_drain();
    endtask

    initial begin
        int s;
        exp_t e;
        // Reset state
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_Q", int'(Q), 0);
        chk("rst_R", int'(R), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        @(negedge clk);

        // 1. Basic divide
        do_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, W);
        // 2. Extremes
        do_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, W);
        do_div(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, W);
        do_div(8'd7, 8'd7, 8'd1, 8'd0, 1'b0, W);
        // 3. Divide by zero, held afterwards, cleared by the next accept
        do_div(8'd5, 8'd0, 8'd255, 8'd5, 1'b1, 0);
        repeat (3) @(negedge clk);
        chk("hold_Q", int'(Q), 255);
        chk("hold_R", int'(R), 5);
        chk("hold_dbz", int'(div_by_zero), 1);
        e.q = 8'd13; e.r = 8'd1; e.z = 1'b0; e.edge_no = cyc + 1 + W;
        sb.push_back(e);
        issue(8'd92, 8'd7, s);
        chk("dbz_cleared", int'(div_by_zero), 0);
        chk("Q_cleared", int'(Q), 0);
        wait_drain();

        // 4. Start while busy is ignored
        e.q = 8'd11; e.r = 8'd1; e.z = 1'b0; e.edge_no = cyc + 1 + W;
        sb.push_back(e);
        issue(8'd100, 8'd9, s);
        while (cyc < s + 3) @(negedge clk);
        A = 8'd1; B = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (12) @(negedge clk);   // a queued second op would show as a spurious done

        // 5. Reset mid-operation abandons it
        issue(8'd200, 8'd7, s);
        while (cyc < s + 4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_Q", int'(Q), 0);
        chk("midrst_R", int'(R), 0);
        repeat (12) @(negedge clk);
        do_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, W);

        // 6. Dividend below divisor
        do_div(8'd3, 8'd10, 8'd0, 8'd3, 1'b0, EE ? 0 : W);
        do_div(8'd0, 8'd5, 8'd0, 8'd0, 1'b0, EE ? 0 : W);
        do_div(8'd9, 8'd10, 8'd0, 8'd9, 1'b0, EE ? 0 : W);
        do_div(8'd10, 8'd10, 8'd1, 8'd0, 1'b0, W);
        do_div(8'd0, 8'd0, 8'd255, 8'd0, 1'b1, 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
